// File: rtl/pipe_cache_pkg.sv
// Shared cache definitions: controller states and address-split width helpers.
package pipe_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } cache_state_e;

    // Word-offset field width for a line of 'words' 32-bit words.
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    // Line-index field width for 'lines' cache lines.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: whatever remains above index, offset and the byte bits.
    function automatic int tag_w(input int addr_w, input int lines, input int words);
        return addr_w - 2 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage: data RAM, tag RAM and valid flags; one write port, async read.
module icache_line_array
    import pipe_cache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = 4,
    parameter int TAG_W = 25
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       clear_all,
    input  logic                       wr_en,
    input  logic [idx_w(LINES)-1:0]    wr_idx,
    input  logic [off_w(WORDS)-1:0]    wr_off,
    input  logic [31:0]                wr_data,
    input  logic                       set_valid,
    input  logic [TAG_W-1:0]           set_tag,
    input  logic [idx_w(LINES)-1:0]    rd_idx,
    input  logic [off_w(WORDS)-1:0]    rd_off,
    output logic [31:0]                rd_data,
    output logic [TAG_W-1:0]           rd_tag,
    output logic                       rd_valid
);

    logic [31:0]      data_ram [LINES][WORDS];
    logic [TAG_W-1:0] tag_ram  [LINES];
    logic [LINES-1:0] valid;

    // Data and tag storage carry no reset; the valid flags gate their use.
    always_ff @(posedge clock) begin
        if (wr_en)     data_ram[wr_idx][wr_off] <= wr_data;
        if (set_valid) tag_ram[wr_idx]          <= set_tag;
    end

    // Valid flags: clear-all dominates a same-cycle set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)        valid <= '0;
        else if (clear_all) valid <= '0;
        else if (set_valid) valid[wr_idx] <= 1'b1;
    end

    assign rd_data  = data_ram[rd_idx][rd_off];
    assign rd_tag   = tag_ram[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/pipe_icache.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
module pipe_icache
    import pipe_cache_pkg::*;
#(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       ins,
    output logic              imem_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid
);

    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int BASE_W = TAG_W + IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    cache_state_e      state, state_n;
    logic [OFF_W-1:0]  word_cnt, cnt_n;
    logic [BASE_W-1:0] line_base, base_n;
    logic              wr_en, set_valid, hit;
    logic [31:0]       rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;

    // pc fields
    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc_bits;

    assign pc_off         = pc[2 +: OFF_W];
    assign pc_idx         = pc[2+OFF_W +: IDX_W];
    assign pc_tag         = pc[ADDR_W-1 -: TAG_W];
    assign unused_pc_bits = ^pc[1:0];

    icache_line_array #(
        .LINES (LINES),
        .WORDS (WORDS_PER_LINE),
        .TAG_W (TAG_W)
    ) u_array (
        .clock     (clock),
        .resetn    (resetn),
        .clear_all (flush),
        .wr_en     (wr_en),
        .wr_idx    (line_base[IDX_W-1:0]),
        .wr_off    (word_cnt),
        .wr_data   (mem_rdata),
        .set_valid (set_valid),
        .set_tag   (line_base[BASE_W-1:IDX_W]),
        .rd_idx    (pc_idx),
        .rd_off    (pc_off),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid)
    );

    // Hit only while idle, so refill and the DONE bubble always stall IF.
    assign hit        = (state == IDLE) && rd_valid && (rd_tag == pc_tag);
    assign imem_ready = hit;
    assign ins        = hit ? rd_data : 32'h0;
    assign mem_req    = (state == REFILL);
    assign mem_addr   = {line_base, word_cnt, 2'b00};

    // State, refill counter and latched line base.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            word_cnt  <= '0;
            line_base <= '0;
        end else begin
            state     <= state_n;
            word_cnt  <= cnt_n;
            line_base <= base_n;
        end
    end

    // Next-state and array write control; flush beats any refill progress.
    always_comb begin
        state_n   = state;
        cnt_n     = word_cnt;
        base_n    = line_base;
        wr_en     = 1'b0;
        set_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && !hit) begin
                    state_n = REFILL;
                    base_n  = {pc_tag, pc_idx};
                    cnt_n   = '0;
                end
            end
            REFILL: begin
                if (flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (mem_valid) begin
                    wr_en = 1'b1;
                    cnt_n = word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        set_valid = 1'b1;
                        state_n   = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipe_icache.sv
// Directed bench for pipe_icache (8 lines x 4 words).
module tb_pipe_icache;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] ins;
    logic        imem_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    int tests = 0;
    int fails = 0;

    pipe_icache #(.LINES(8), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pc         (pc),
        .flush      (flush),
        .ins        (ins),
        .imem_ready (imem_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request, checks its address, then supplies one word.
    task automatic serve_word(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic with_flush);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
        mem_rdata = data;
        mem_valid = 1'b1;
        flush     = with_flush;
        @(negedge clock);
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        pc        = 32'h0;
        flush     = 1'b0;
        mem_rdata = 32'h0;
        mem_valid = 1'b0;
        #1;
        chk("rst_ready", {31'd0, imem_ready}, 32'd0);
        chk("rst_ins",   ins, 32'h0);
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // 1: cold miss at 0x00, fill A0..A3
        #1 chk("t1_miss", {31'd0, imem_ready}, 32'd0);
        serve_word("t1_w0", 32'h00, 32'hA000_0000, 1'b0);
        serve_word("t1_w1", 32'h04, 32'hA000_0001, 1'b0);
        serve_word("t1_w2", 32'h08, 32'hA000_0002, 1'b0);
        serve_word("t1_w3", 32'h0C, 32'hA000_0003, 1'b0);
        chk("t1_done_ready", {31'd0, imem_ready}, 32'd0);
        chk("t1_done_req",   {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        chk("t1_hit", {31'd0, imem_ready}, 32'd1);
        chk("t1_ins", ins, 32'hA000_0000);

        // 2: same-line hit at 0x0C
        pc = 32'h0C;
        #1;
        chk("t2_hit", {31'd0, imem_ready}, 32'd1);
        chk("t2_ins", ins, 32'hA000_0003);
        @(negedge clock);
        chk("t2_req", {31'd0, mem_req}, 32'd0);

        // 3: conflicting tag at 0x80 evicts line 0
        pc = 32'h80;
        #1 chk("t3_miss", {31'd0, imem_ready}, 32'd0);
        chk("t3_ins0", ins, 32'h0);
        serve_word("t3_w0", 32'h80, 32'hB000_0000, 1'b0);
        serve_word("t3_w1", 32'h84, 32'hB000_0001, 1'b0);
        serve_word("t3_w2", 32'h88, 32'hB000_0002, 1'b0);
        serve_word("t3_w3", 32'h8C, 32'hB000_0003, 1'b0);
        @(negedge clock);
        chk("t3_ins", ins, 32'hB000_0000);
        pc = 32'h00;
        #1 chk("t3_remiss", {31'd0, imem_ready}, 32'd0);

        // 4: stalled memory between words 1 and 2
        serve_word("t4_w0", 32'h00, 32'hA000_0000, 1'b0);
        serve_word("t4_w1", 32'h04, 32'hA000_0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t4_hold_req",  {31'd0, mem_req}, 32'd1);
            chk("t4_hold_addr", mem_addr, 32'h08);
        end
        serve_word("t4_w2", 32'h08, 32'hA000_0002, 1'b0);
        serve_word("t4_w3", 32'h0C, 32'hA000_0003, 1'b0);
        @(negedge clock);
        pc = 32'h04;
        #1 chk("t4_ins", ins, 32'hA000_0001);

        // 5: flush mid-refill, then flush alongside the last word
        pc = 32'h10;
        serve_word("t5_w0", 32'h10, 32'hC000_0000, 1'b0);
        serve_word("t5_w1", 32'h14, 32'hC000_0001, 1'b0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("t5_abort_req",   {31'd0, mem_req}, 32'd0);
        chk("t5_abort_ready", {31'd0, imem_ready}, 32'd0);
        @(negedge clock);
        chk("t5_restart_addr", mem_addr, 32'h10);
        serve_word("t5_r0", 32'h10, 32'hC000_0000, 1'b0);
        serve_word("t5_r1", 32'h14, 32'hC000_0001, 1'b0);
        serve_word("t5_r2", 32'h18, 32'hC000_0002, 1'b0);
        serve_word("t5_r3", 32'h1C, 32'hC000_0003, 1'b1);
        flush = 1'b1;
        #1;
        chk("t5_lastflush_ready", {31'd0, imem_ready}, 32'd0);
        chk("t5_lastflush_req",   {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        chk("t5_idleflush_req", {31'd0, mem_req}, 32'd0);
        flush = 1'b0;
        serve_word("t5_f0", 32'h10, 32'hC000_0000, 1'b0);
        serve_word("t5_f1", 32'h14, 32'hC000_0001, 1'b0);
        serve_word("t5_f2", 32'h18, 32'hC000_0002, 1'b0);
        serve_word("t5_f3", 32'h1C, 32'hC000_0003, 1'b0);
        @(negedge clock);
        chk("t5_ins", ins, 32'hC000_0000);
        pc = 32'h04;
        #1 chk("t5_line0_flushed", {31'd0, imem_ready}, 32'd0);

        // 6: async reset during refill
        serve_word("t6_w0", 32'h00, 32'hD000_0000, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_req",   {31'd0, mem_req}, 32'd0);
        chk("t6_rst_ready", {31'd0, imem_ready}, 32'd0);
        chk("t6_rst_ins",   ins, 32'h0);
        chk("t6_rst_addr",  mem_addr, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        pc     = 32'h10;
        #1 chk("t6_c_miss", {31'd0, imem_ready}, 32'd0);
        @(negedge clock);
        chk("t6_c_req",  {31'd0, mem_req}, 32'd1);
        chk("t6_c_addr", mem_addr, 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
